// File: rtl/reg_op_sequencer_pkg.sv
// Shared widths, op-code and FSM encodings for the register-operation sequencer.
// Also holds the helpers that decide which register reads an op needs.
package reg_op_sequencer_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_LDI = 3'b101,
        OP_MOV = 3'b110,
        OP_CLR = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_B  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // LDI and CLR never touch the register file before writing.
    function automatic logic opNeedsA(op_e op);
        return (op != OP_LDI) && (op != OP_CLR);
    endfunction

    function automatic logic opNeedsB(op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

endpackage

// File: rtl/reg_op_sequencer_if.sv
// Request handshake plus register-file port of the sequencer.
// The slave side is the sequencer; the master side issues requests and owns the register file.
interface reg_op_sequencer_if;
    import reg_op_sequencer_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [OP_W-1:0]     req_op;
    logic [ADDR_W-1:0]   req_ra;
    logic [ADDR_W-1:0]   req_rb;
    logic [ADDR_W-1:0]   req_rd;
    logic [DATA_W-1:0]   req_imm;

    logic [ADDR_W-1:0]   rf_address;
    logic                rf_load;
    logic [DATA_W-1:0]   rf_d_in;
    logic [DATA_W-1:0]   rf_q_out;

    logic                done;
    logic [DATA_W-1:0]   result;
    logic                flag_z;
    logic                flag_c;

    modport slave (
        input  req_valid, req_op, req_ra, req_rb, req_rd, req_imm, rf_q_out,
        output req_ready, rf_address, rf_load, rf_d_in, done, result, flag_z, flag_c
    );

    modport master (
        output req_valid, req_op, req_ra, req_rb, req_rd, req_imm, rf_q_out,
        input  req_ready, rf_address, rf_load, rf_d_in, done, result, flag_z, flag_c
    );

endinterface

// File: rtl/reg_op_sequencer_alu8.sv
// Combinational 8-bit datapath: result and carry/borrow for every op code.
// SUB reports borrow, which is bit 8 of the zero-extended difference.
module alu8
    import reg_op_sequencer_pkg::*;
(
    input  op_e               op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide     = '0;
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                wide     = {1'b0, a_i} + {1'b0, b_i};
                result_o = wide[DATA_W-1:0];
                carry_o  = wide[DATA_W];
            end
            OP_SUB: begin
                wide     = {1'b0, a_i} - {1'b0, b_i};
                result_o = wide[DATA_W-1:0];
                carry_o  = wide[DATA_W];
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_LDI:  result_o = imm_i;
            OP_MOV:  result_o = a_i;
            OP_CLR:  result_o = '0;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/reg_op_sequencer.sv
// Sequences read-read-write register operations against an external register file.
// Both reads finish before the write, so a destination aliasing a source sees the old value.
module reg_op_sequencer
    import reg_op_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    reg_op_sequencer_if.slave bus
);

    state_e              state_q, state_d;
    op_e                 op_q;
    logic [ADDR_W-1:0]   ra_q, rb_q, rd_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   opA_q, opB_q;
    logic [DATA_W-1:0]   result_q;
    logic                flagZ_q, flagC_q;

    logic                accept;
    logic                readyC;
    logic                loadC;
    logic                doneC;
    logic [ADDR_W-1:0]   addrC;
    logic [DATA_W-1:0]   dInC;
    logic [DATA_W-1:0]   aluResult;
    logic                aluCarry;

    alu8 u_alu8 (
        .op_i     (op_q),
        .a_i      (opA_q),
        .b_i      (opB_q),
        .imm_i    (imm_q),
        .result_o (aluResult),
        .carry_o  (aluCarry)
    );

    assign accept = (state_q == ST_IDLE) && bus.req_valid;

    always_comb begin
        state_d = state_q;
        readyC  = 1'b0;
        loadC   = 1'b0;
        doneC   = 1'b0;
        addrC   = '0;
        dInC    = '0;
        case (state_q)
            ST_IDLE: begin
                readyC = 1'b1;
                if (bus.req_valid)
                    state_d = opNeedsA(op_e'(bus.req_op)) ? ST_RD_A : ST_WRITE;
            end
            ST_RD_A: begin
                addrC   = ra_q;
                state_d = opNeedsB(op_q) ? ST_RD_B : ST_WRITE;
            end
            ST_RD_B: begin
                addrC   = rb_q;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                loadC   = 1'b1;
                addrC   = rd_q;
                dInC    = aluResult;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                doneC   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields are captured only on the accepting edge, so mid-flight changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            ra_q     <= '0;
            rb_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
            result_q <= '0;
            flagZ_q  <= 1'b0;
            flagC_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= op_e'(bus.req_op);
                ra_q  <= bus.req_ra;
                rb_q  <= bus.req_rb;
                rd_q  <= bus.req_rd;
                imm_q <= bus.req_imm;
            end
            if (state_q == ST_RD_A)
                opA_q <= bus.rf_q_out;
            if (state_q == ST_RD_B)
                opB_q <= bus.rf_q_out;
            if (state_q == ST_WRITE) begin
                result_q <= aluResult;
                flagZ_q  <= (aluResult == '0);
                flagC_q  <= aluCarry;
            end
        end
    end

    assign bus.req_ready  = readyC;
    assign bus.rf_load    = loadC;
    assign bus.rf_address = addrC;
    assign bus.rf_d_in    = dInC;
    assign bus.done       = doneC;
    assign bus.result     = result_q;
    assign bus.flag_z     = flagZ_q;
    assign bus.flag_c     = flagC_q;

endmodule

// File: doc/reg_op_sequencer.md
REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled only on the rising edge of clk.
REQ-004 req_valid  input  1  an operation request is present.
REQ-005 req_ready  output  1  the sequencer can accept a request.
REQ-006 req_op  input  3  operation code (see REQ-012).
REQ-007 req_ra, req_rb, req_rd  input  3 each  source A, source B and destination register addresses.
REQ-008 req_imm  input  8  immediate operand.
REQ-009 rf_address  output  3  drives the register-file address port.
REQ-010 rf_load, rf_d_in  output  1, 8  register-file write enable and write data.
REQ-011 rf_q_out  input  8  combinational read data from the register file; done, result, flag_z, flag_c  output  1, 8, 1, 1  completion pulse, last written value, zero flag, carry/borrow flag.

Function
REQ-012 Op codes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LDI (rd<=imm), 110 MOV (rd<=ra), 111 CLR (rd<=0).
REQ-013 The FSM SHALL have the states IDLE, RD_A, RD_B, WRITE and DONE.
REQ-014 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 in IDLE, and all req_* fields are latched at that edge.
REQ-015 Transitions after acceptance:
- ADD/SUB/AND/OR/XOR: IDLE->RD_A->RD_B->WRITE->DONE->IDLE.
- MOV: IDLE->RD_A->WRITE.
- LDI/CLR: IDLE->WRITE.
REQ-016 In RD_A, rf_address SHALL equal the latched ra, and rf_q_out SHALL be captured into operand A at the end of the cycle; RD_B does the same with rb into operand B.
REQ-017 In WRITE: rf_load=1, rf_address=latched rd, rf_d_in=computed result; rf_load SHALL be 0 in every other state.
REQ-018 In IDLE and DONE, rf_address SHALL be 0 and rf_d_in SHALL be 0.
REQ-019 done SHALL be 1 for exactly the DONE cycle. Latency from the accept edge to done high: 4 cycles for ALU ops, 3 for MOV, 2 for LDI/CLR.
REQ-020 Arithmetic is 8-bit modulo:
- ADD: carry = bit 8 of the 9-bit sum.
- SUB: A-B; flag_c = 1 when A<B (borrow).
- Logic/LDI/MOV/CLR: flag_c = 0.
REQ-021 flag_z = (result==0). result, flag_z and flag_c SHALL update only at the end of WRITE and hold otherwise.
REQ-022 ra, rb and rd MAY alias: both reads complete before the write, so rd==ra uses the old value.
REQ-023 req_valid while not in IDLE SHALL be ignored, and the in-flight latched fields SHALL NOT change.
REQ-024 A back-to-back request SHALL be accepted in the IDLE cycle immediately following DONE; there is no extra idle cycle.

Reset
REQ-025 On reset: state=IDLE, req_ready=1, rf_load=0, rf_address=0, rf_d_in=0, done=0, result=0, flag_z=0, flag_c=0, operand registers=0.
REQ-026 Reset asserted in any state, including WRITE, SHALL take priority: rf_load is 0 in the following cycle, and the aborted operation produces no write and no done.

Structure
REQ-027 A shared package SHALL hold the op-code constants, the FSM state encoding and the widths (data 8, address 3).
REQ-028 A combinational sub-module alu8 SHALL compute result and carry from op, A, B and imm; reg_op_sequencer instantiates it once.

Verification
REQ-029 Reset, then ADD ra=1 (0xF0), rb=2 (0x20), rd=3 -> rf_load=1 at addr 3 with d_in 0x10, flag_c=1, flag_z=0, done 4 cycles after accept.
REQ-030 SUB A=0x05, B=0x05, rd=ra -> write 0x00, flag_z=1, flag_c=0. Then SUB A=0x03, B=0x04 -> 0xFF, flag_c=1.
REQ-031 LDI rd=7, imm=0xA5 -> single WRITE cycle with addr 7 / 0xA5, done 2 cycles after accept. MOV ra=7->rd=0 -> writes 0xA5.
REQ-032 Hold req_valid=1 continuously with changing fields -> only values present at IDLE edges are accepted; mid-operation changes have no effect; ready is low for 4 cycles per ALU op.
REQ-033 Assert reset during RD_B of an XOR -> no rf_load pulse, no done, outputs at reset values, req_ready=1 on the next cycle.
REQ-034 CLR rd=4 after LDI rd=4 -> register 4 reads 0x00, flag_z=1, flag_c=0.
